// File: rtl/instr_encoder_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder_unit_if
// Description : Request/response bundle for the RV32I instruction encoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_encoder_unit_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        fmt;
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        func3;
    logic              func1;
    logic [31:0]       imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;
    logic              err_seen;

    modport slave (
        input  in_valid, fmt, opcode, rd, rs1, rs2, func3, func1, imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr, out_err, err_seen
    );

    modport master (
        output in_valid, fmt, opcode, rd, rs1, rs2, func3, func1, imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, out_err, err_seen
    );
endinterface
`default_nettype wire

// File: rtl/instr_encoder_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder_unit
// Description : Two-stage streaming RV32I field-to-word encoder with range
//               checking, NOP substitution on error and a word-address counter.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder_unit #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 restart,
    instr_encoder_unit_if.slave  bus
);

    localparam logic [2:0]        C_FMT_R = 3'd0;
    localparam logic [2:0]        C_FMT_I = 3'd1;
    localparam logic [2:0]        C_FMT_S = 3'd2;
    localparam logic [2:0]        C_FMT_B = 3'd3;
    localparam logic [2:0]        C_FMT_U = 3'd4;
    localparam logic [2:0]        C_FMT_J = 3'd5;
    localparam logic [31:0]       C_NOP   = 32'h0000_0013;
    localparam logic [6:0]        C_OP_IMM = 7'b0010011;
    localparam logic [ADDR_W-1:0] C_BASE  = ADDR_W'(BASE_ADDR);

    // Stage 1: registered request
    logic              s1_valid_q;
    logic [2:0]        fmt_q;
    logic [6:0]        opcode_q;
    logic [4:0]        rd_q;
    logic [4:0]        rs1_q;
    logic [4:0]        rs2_q;
    logic [2:0]        func3_q;
    logic              func1_q;
    logic [31:0]       imm_q;

    // Stage 2: registered result
    logic              out_valid_q;
    logic [31:0]       out_instr_q;
    logic              out_err_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic              err_seen_q;

    logic              w_s2_load;
    logic              w_s1_load;
    logic              w_is_shift;
    logic              w_imm12_ok;
    logic              w_imm13_ok;
    logic              w_imm21_ok;
    logic [31:0]       w_enc;
    logic              w_err;

    assign w_s2_load = !out_valid_q || bus.out_ready;
    assign w_s1_load = !s1_valid_q || w_s2_load;

    // A value fits an N-bit signed field when bits [31:N-1] are all equal.
    assign w_imm12_ok = (&imm_q[31:11]) || !(|imm_q[31:11]);
    assign w_imm13_ok = (&imm_q[31:12]) || !(|imm_q[31:12]);
    assign w_imm21_ok = (&imm_q[31:20]) || !(|imm_q[31:20]);
    assign w_is_shift = (opcode_q == C_OP_IMM) && (func3_q[1:0] == 2'b01);

    always_comb begin
        w_enc = {7'b0, rs2_q, rs1_q, func3_q, rd_q, opcode_q};
        w_err = 1'b0;
        case (fmt_q)
            C_FMT_R: w_enc[31:25] = {1'b0, func1_q, 5'b0};
            C_FMT_I: begin
                if (w_is_shift) begin
                    w_enc[31:20] = {1'b0, func1_q, 5'b0, imm_q[4:0]};
                    w_err        = |imm_q[31:5];
                end else begin
                    w_enc[31:20] = imm_q[11:0];
                    w_err        = !w_imm12_ok;
                end
            end
            C_FMT_S: begin
                w_enc[31:25] = imm_q[11:5];
                w_enc[11:7]  = imm_q[4:0];
                w_err        = !w_imm12_ok;
            end
            C_FMT_B: begin
                w_enc[31:25] = {imm_q[12], imm_q[10:5]};
                w_enc[11:7]  = {imm_q[4:1], imm_q[11]};
                w_err        = !w_imm13_ok || imm_q[0];
            end
            C_FMT_U: begin
                w_enc[31:12] = imm_q[19:0];
                w_err        = |imm_q[31:20];
            end
            C_FMT_J: begin
                w_enc[31:12] = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12]};
                w_err        = !w_imm21_ok || imm_q[0];
            end
            default: w_err = 1'b1;
        endcase
        if (w_err) begin
            w_enc = C_NOP;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            fmt_q       <= 3'd0;
            opcode_q    <= 7'd0;
            rd_q        <= 5'd0;
            rs1_q       <= 5'd0;
            rs2_q       <= 5'd0;
            func3_q     <= 3'd0;
            func1_q     <= 1'b0;
            imm_q       <= 32'd0;
            out_valid_q <= 1'b0;
            out_instr_q <= 32'd0;
            out_err_q   <= 1'b0;
            out_addr_q  <= C_BASE;
            err_seen_q  <= 1'b0;
        end else if (restart) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_addr_q  <= C_BASE;
            err_seen_q  <= 1'b0;
        end else begin
            if (w_s1_load) begin
                s1_valid_q <= bus.in_valid;
                if (bus.in_valid) begin
                    fmt_q    <= bus.fmt;
                    opcode_q <= bus.opcode;
                    rd_q     <= bus.rd;
                    rs1_q    <= bus.rs1;
                    rs2_q    <= bus.rs2;
                    func3_q  <= bus.func3;
                    func1_q  <= bus.func1;
                    imm_q    <= bus.imm;
                end
            end
            if (w_s2_load) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_instr_q <= w_enc;
                    out_err_q   <= w_err;
                    if (w_err) begin
                        err_seen_q <= 1'b1;
                    end
                end
            end
            // Address follows the word in S2; it wraps naturally at 2^ADDR_W.
            if (out_valid_q && bus.out_ready) begin
                out_addr_q <= out_addr_q + 1'b1;
            end
        end
    end

    assign bus.in_ready  = w_s1_load;
    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_err   = out_err_q;
    assign bus.err_seen  = err_seen_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder_unit
// Description : Scoreboard-based bench for instr_encoder_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder_unit;

    localparam int AW = 10;

    logic clk = 1'b0;
    logic reset;
    logic restart;
    logic restart2 = 1'b0;

    always #5 clk = ~clk;

    instr_encoder_unit_if #(.ADDR_W(AW)) bus ();
    instr_encoder_unit_if #(.ADDR_W(2))  bus2 ();

    instr_encoder_unit #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
        .clk(clk), .reset(reset), .restart(restart), .bus(bus.slave));

    instr_encoder_unit #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
        .clk(clk), .reset(reset), .restart(restart2), .bus(bus2.slave));

    typedef struct packed {
        logic [31:0]   instr;
        logic [AW-1:0] addr;
        logic          err;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    logic [AW-1:0] exp_addr;
    int            n_tests = 0;
    int            n_fail  = 0;

    // Scoreboard monitor: pops one expectation per output handshake.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_extra: got instr=%h addr=%0d, required no output",
                         bus.out_instr, bus.out_addr);
            end else begin
                mon_e = sb.pop_front();
                if (bus.out_instr !== mon_e.instr || bus.out_addr !== mon_e.addr ||
                    bus.out_err !== mon_e.err) begin
                    n_fail++;
                    $display("FAIL sb_word: got instr=%h addr=%0d err=%b, required instr=%h addr=%0d err=%b",
                             bus.out_instr, bus.out_addr, bus.out_err,
                             mon_e.instr, mon_e.addr, mon_e.err);
                end
            end
        end
    end

    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                        input logic [4:0] a, input logic [4:0] b, input logic [2:0] f3,
                        input logic f1, input logic [31:0] im,
                        input logic [31:0] exp_instr, input logic exp_err);
        logic acc = 1'b0;
        exp_t e;
        bus.in_valid = 1'b1; bus.fmt = f; bus.opcode = op; bus.rd = d;
        bus.rs1 = a; bus.rs2 = b; bus.func3 = f3; bus.func1 = f1; bus.imm = im;
        e.instr = exp_instr; e.addr = exp_addr; e.err = exp_err;
        sb.push_back(e);
        exp_addr++;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        bus.in_valid = 1'b0;
        if (!acc) begin
            n_tests++; n_fail++;
            $display("FAIL send_timeout: got in_ready=0 for 200 cycles, required accept");
        end
    endtask

    task automatic drain_check(input string name);
        for (int k = 0; k < 100 && sb.size() != 0; k++) @(posedge clk);
        #1;
        n_tests++;
        if (sb.size() !== 0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d words outstanding, required 0", name, sb.size());
        end
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
        sb.delete();
        exp_addr = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; restart = 1'b0;
        bus.in_valid = 0; bus.out_ready = 1; bus.fmt = 0; bus.opcode = 0; bus.rd = 0;
        bus.rs1 = 0; bus.rs2 = 0; bus.func3 = 0; bus.func1 = 0; bus.imm = 0;
        bus2.in_valid = 0; bus2.out_ready = 1; bus2.fmt = 0; bus2.opcode = 7'h33; bus2.rd = 0;
        bus2.rs1 = 1; bus2.rs2 = 2; bus2.func3 = 0; bus2.func1 = 0; bus2.imm = 0;
        exp_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({bus.in_ready, bus.out_valid, bus.out_err, bus.err_seen} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_flags: got rdy/vld/err/seen=%b%b%b%b, required 1000",
                     bus.in_ready, bus.out_valid, bus.out_err, bus.err_seen);
        end
        n_tests++;
        if (bus.out_instr !== 32'h0) begin
            n_fail++; $display("FAIL reset_instr: got %h, required 00000000", bus.out_instr);
        end
        n_tests++;
        if (bus.out_addr !== '0) begin
            n_fail++; $display("FAIL reset_addr: got %0d, required 0", bus.out_addr);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_r_latency();
        bus.out_ready = 1'b1;
        send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'h0, 32'h002081B3, 1'b0);
        @(negedge clk);
        n_tests++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL lat_n1: got out_valid=%b, required 0", bus.out_valid);
        end
        @(negedge clk);
        n_tests++;
        if (bus.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL lat_n2: got out_valid=%b, required 1", bus.out_valid);
        end
        @(posedge clk); #1;
        send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'h0, 32'h402081B3, 1'b0);
        drain_check("r_type");
    endtask

    task automatic test_formats();
        bus.out_ready = 1'b1;
        send(3'd1, 7'h13, 5'd5, 5'd0, 5'd31, 3'd0, 1'b0, 32'hFFFF_FFFF, 32'hFFF00293, 1'b0);
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2047, 32'h7FF00093, 1'b0);
        send(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd5, 1'b1, 32'd3, 32'h40315093, 1'b0);
        send(3'd2, 7'h23, 5'd31, 5'd1, 5'd2, 3'd2, 1'b0, 32'd8, 32'h0020A423, 1'b0);
        send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'hFFFF_FFFC, 32'hFE208EE3, 1'b0);
        send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd4094, 32'h7E000FE3, 1'b0);
        send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345, 32'h123452B7, 1'b0);
        send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2048, 32'h001000EF, 1'b0);
        drain_check("formats");
        n_tests++;
        if (bus.err_seen !== 1'b0) begin
            n_fail++; $display("FAIL formats_err_seen: got %b, required 0", bus.err_seen);
        end
    endtask

    task automatic test_errors();
        do_restart();
        bus.out_ready = 1'b1;
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2048, 32'h13, 1'b1);
        send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd3, 32'h13, 1'b1);
        send(3'd7, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, 32'h13, 1'b1);
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFF_F7FF, 32'h13, 1'b1);
        send(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd1, 1'b0, 32'd32, 32'h13, 1'b1);
        send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h100000, 32'h13, 1'b1);
        send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd3, 32'h13, 1'b1);
        drain_check("errors");
        n_tests++;
        if (bus.err_seen !== 1'b1) begin
            n_fail++; $display("FAIL err_seen_set: got %b, required 1", bus.err_seen);
        end
        send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'h0, 32'h002081B3, 1'b0);
        drain_check("errors_ok");
        n_tests++;
        if (bus.err_seen !== 1'b1) begin
            n_fail++; $display("FAIL err_seen_sticky: got %b, required 1", bus.err_seen);
        end
    endtask

    task automatic test_backpressure();
        int          acc_cnt  = 0;
        int          unstable = 0;
        logic [31:0] held     = '0;
        do_restart();
        bus.out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    send(3'd0, 7'h33, 5'(i + 4), 5'd1, 5'd2, 3'd0, 1'b0, 32'h0,
                         32'h00208033 | (32'(i + 4) << 7), 1'b0);
            end
            begin
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    if (bus.in_valid && bus.in_ready) acc_cnt++;
                    if (c == 2) held = bus.out_instr;
                    if (c > 2 && bus.out_instr !== held) unstable++;
                end
                n_tests++;
                if (acc_cnt !== 2) begin
                    n_fail++; $display("FAIL bp_accepts: got %0d, required 2", acc_cnt);
                end
                n_tests++;
                if (bus.in_ready !== 1'b0) begin
                    n_fail++; $display("FAIL bp_in_ready: got %b, required 0", bus.in_ready);
                end
                n_tests++;
                if (unstable !== 0) begin
                    n_fail++; $display("FAIL bp_stable: got %0d changes, required 0", unstable);
                end
                @(posedge clk); #1;
                bus.out_ready = 1'b1;
            end
        join
        drain_check("backpressure");
    endtask

    task automatic test_restart();
        bus.out_ready = 1'b1;
        send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'h0, 32'h002081B3, 1'b0);
        drain_check("restart_pre");
        bus.out_ready = 1'b0;
        send(3'd6, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'h0, 32'h13, 1'b1);
        send(3'd0, 7'h33, 5'd4, 5'd1, 5'd2, 3'd0, 1'b0, 32'h0, 32'h00208233, 1'b0);
        n_tests++;
        if (bus.err_seen !== 1'b1) begin
            n_fail++; $display("FAIL restart_pre_err: got %b, required 1", bus.err_seen);
        end
        bus.in_valid = 1'b1;
        do_restart();
        bus.in_valid = 1'b0;
        n_tests++;
        if ({bus.out_valid, bus.err_seen} !== 2'b00 || bus.out_addr !== '0) begin
            n_fail++;
            $display("FAIL restart_state: got vld=%b seen=%b addr=%0d, required 0 0 0",
                     bus.out_valid, bus.err_seen, bus.out_addr);
        end
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL restart_flushed: got out_valid=%b, required 0", bus.out_valid);
        end
        send(3'd0, 7'h33, 5'd5, 5'd1, 5'd2, 3'd0, 1'b0, 32'h0, 32'h002082B3, 1'b0);
        drain_check("restart_post");
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        send(3'd7, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'h0, 32'h13, 1'b1);
        send(3'd0, 7'h33, 5'd4, 5'd1, 5'd2, 3'd0, 1'b0, 32'h0, 32'h00208233, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if ({bus.in_ready, bus.out_valid, bus.out_err, bus.err_seen} !== 4'b1000 ||
            bus.out_addr !== '0 || bus.out_instr !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset: got rdy/vld/err/seen=%b%b%b%b addr=%0d instr=%h, required 1000 0 00000000",
                     bus.in_ready, bus.out_valid, bus.out_err, bus.err_seen, bus.out_addr, bus.out_instr);
        end
        sb.delete();
        exp_addr = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.out_ready = 1'b1;
        send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'h0, 32'h002081B3, 1'b0);
        drain_check("async_post");
    endtask

    task automatic test_wrap();
        logic [1:0]  got_addr[5];
        logic [31:0] got_instr[5];
        int          n      = 0;
        int          stalls = 0;
        bus2.out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            bus2.in_valid = (c < 5);
            bus2.rd       = 5'(c);
            @(negedge clk);
            if (c < 5 && !bus2.in_ready) stalls++;
            if (bus2.out_valid && n < 5) begin
                got_addr[n]  = bus2.out_addr;
                got_instr[n] = bus2.out_instr;
                n++;
            end
            @(posedge clk); #1;
        end
        bus2.in_valid = 1'b0;
        n_tests++;
        if (n !== 5 || stalls !== 0) begin
            n_fail++; $display("FAIL wrap_count: got %0d words %0d stalls, required 5 0", n, stalls);
        end
        for (int i = 0; i < n; i++) begin
            n_tests++;
            if (got_addr[i] !== 2'(i) || got_instr[i] !== (32'h00208033 | (32'(i) << 7))) begin
                n_fail++;
                $display("FAIL wrap_word%0d: got addr=%0d instr=%h, required addr=%0d instr=%h",
                         i, got_addr[i], got_instr[i], 2'(i), 32'h00208033 | (32'(i) << 7));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_r_latency();
        test_formats();
        test_errors();
        test_backpressure();
        test_restart();
        test_async_reset();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_encoder_unit.md
Name: instr_encoder_unit

Overview:
- Streaming RV32I instruction encoder: the inverse of the instruction field decoder.
- Accepts field-level requests (format, opcode, register indices, func3/func1, immediate), packs them into a 32-bit instruction word, and emits the word with its target word address.
- Used by the test/program loader to build instruction memory images in hardware.
- Two-stage valid/ready pipeline with range checking and an address counter.

Parameters:
- ADDR_W, 10, width of the instruction word address.
- BASE_ADDR, 0, word address assigned to the first instruction after reset/restart.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- restart  input  1  synchronous: flush pipeline, reload address counter, clear err_seen.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid & in_ready.
- fmt  input  3  format code: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
- opcode  input  7  instr[6:0].
- rd  input  5  destination register.
- rs1  input  5  source register 1.
- rs2  input  5  source register 2.
- func3  input  3  instr[14:12].
- func1  input  1  instr[30] for R-format and shift-immediates.
- imm  input  32  signed immediate; B and J take a byte offset.
- out_valid  output  1  encoded word valid.
- out_ready  input  1  downstream ready.
- out_instr  output  32  encoded instruction.
- out_addr  output  ADDR_W  word address of out_instr.
- out_err  output  1  current word is a substituted NOP due to an error.
- err_seen  output  1  sticky: any error since reset/restart.

Behaviour:
- Reset (async, active-high): all pipeline valids 0, out_instr 0, out_err 0, err_seen 0, out_addr BASE_ADDR. in_ready reads 1 after reset.
- Pipeline: S1 registers the request; S2 registers the encoded word and drives the outputs. Encoding and range checks are combinational between S1 and S2.
  - S2 loads when !out_valid | out_ready.
  - S1 loads when !S1_valid | S2 loads.
  - in_ready = !S1_valid | S2 loads.
  - Request accepted in cycle N appears on out_valid in cycle N+2.
  - Throughput 1/cycle while out_ready=1. No drops or duplicates under backpressure.
  - Outputs stay stable while out_valid & !out_ready.
- Common fields: opcode to [6:0]. Unless a format overrides them: rd to [11:7], func3 to [14:12], rs1 to [19:15], rs2 to [24:20].
- R: [31]=0, [30]=func1, [29:25]=0. imm ignored.
- I: [31:20]=imm[11:0]; rs2 ignored.
  - Shift-immediate (opcode 0010011, func3 001 or 101): [31:25]={0,func1,00000}, [24:20]=imm[4:0]. imm must be 0..31.
  - Otherwise imm must be in -2048..2047.
- S: [31:25]=imm[11:5], [11:7]=imm[4:0]. rd ignored. imm must be in -2048..2047.
- B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]. imm must be in -4096..4094 and even.
- U: [31:12]=imm[19:0]. imm must be in 0..0xFFFFF.
- J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]. imm must be in -1048576..1048574 and even.
- Error (illegal fmt or range violation): out_instr=0x00000013 (NOP), out_err=1, err_seen set. The address slot is still consumed.
- Address counter: out_addr is the address of the word in S2. It increments on each output handshake and wraps from 2^ADDR_W-1 to 0.
- restart: takes priority over all handshakes. Next cycle: valids 0, out_addr BASE_ADDR, err_seen 0. Any request presented during the restart cycle is dropped.
- reset mid-stream: in-flight words are lost; state returns to the reset values immediately.

Test Plan:
- R add x3,x1,x2 (op 0x33, f3 0, f1 0) -> 0x002081B3 at addr 0; same request with f1=1 -> 0x402081B3 at addr 1; out_valid 2 cycles after accept.
- I addi x5,x0,-1 -> 0xFFF00293; B beq x1,x2,imm=-4 (op 0x63) -> 0xFE208EE3; J jal x1,imm=2048 (op 0x6F) -> 0x001000EF; all out_err=0.
- Errors: I imm=2048, B imm=3, fmt=7 -> each gives 0x00000013 with out_err=1; err_seen=1 and stays set; addresses advance 0,1,2.
- Backpressure: 4 back-to-back requests with out_ready=0 for 5 cycles -> in_ready drops after 2 accepts; on release, words come out in order at addresses 0..3, none lost or duplicated.
- Wrap: ADDR_W=2, 5 words -> addresses 0,1,2,3,0.
- restart asserted with both stages full -> out_valid 0 next cycle, err_seen 0, next word at BASE_ADDR. Async reset mid-stream -> same state immediately, without waiting for a clock edge.
